drop_controller: RTL and testbench

DROP_CONTROLLER -- requirements
Module: drop_controller

---
 rtl/drop_controller.sv | 162 ++++++++++++++++
 tb/tb_drop_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/drop_controller.sv
// Column-drop controller: per-column fill counters plus a 4-state drop FSM.
// Optional single-level undo is enabled with `define DROP_UNDO_EN.

module drop_col_cnt #(
  parameter int ROWS = 4,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full
);
  assign full = (cnt == CW'(ROWS));

  // Saturating in both directions so a stray strobe can never wrap the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && !full)      cnt <= cnt + CW'(1);
    else if (dec && cnt != '0)  cnt <= cnt - CW'(1);
  end
endmodule

module drop_controller #(
  parameter int COLS  = 4,
  parameter int ROWS  = 4,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             req,
  input  logic [COLS-1:0]  sel_col,
`ifdef DROP_UNDO_EN
  input  logic             undo,
  output logic             undo_done,
`endif
  output logic             ready,
  output logic             done,
  output logic [IDX_W-1:0] cell_index,
  output logic             err_full,
  output logic             err_sel,
  output logic             board_full
);
  localparam int CW  = $clog2(ROWS + 1);
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    IDLE, DECODE, COMMIT, REJECT
`ifdef DROP_UNDO_EN
    , UNDO
`endif
  } state_t;

  state_t                     state, state_n;
  logic [COLS-1:0]            sel_q;
  logic [COLS-1:0]            sel_hot;
  logic                       sel_ok;
  logic [CLW-1:0]             sel_idx;
  logic [COLS-1:0][CW-1:0]    cnt;
  logic [COLS-1:0]            full;
  logic [COLS-1:0]            inc_col;
  logic [COLS-1:0]            dec_col;
  logic                       clr_all;
  logic                       accept;

  assign clr_all = (state == IDLE) && clear;
  assign accept  = (state == IDLE) && !clear && req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sel_q <= '1;
    else if (accept) sel_q <= sel_col;
  end

  // Exactly one zero bit in the captured select is a legal column.
  assign sel_hot = ~sel_q;
  assign sel_ok  = (sel_hot != '0) && ((sel_hot & (sel_hot - COLS'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int c = 0; c < COLS; c++)
      if (!sel_q[c]) sel_idx = CLW'(c);
  end

`ifdef DROP_UNDO_EN
  logic           hist_vld;
  logic [CLW-1:0] hist_col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_vld <= 1'b0;
      hist_col <= '0;
    end else if (clr_all) begin
      hist_vld <= 1'b0;
    end else if (state == COMMIT) begin
      hist_vld <= 1'b1;
      hist_col <= sel_idx;
    end else if (state == UNDO) begin
      hist_vld <= 1'b0;
    end
  end

  assign undo_done = (state == UNDO);
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign inc_col[c] = (state == COMMIT) && (sel_idx == CLW'(c));
`ifdef DROP_UNDO_EN
    assign dec_col[c] = (state == UNDO) && (hist_col == CLW'(c));
`else
    assign dec_col[c] = 1'b0;
`endif
    drop_col_cnt #(.ROWS(ROWS), .CW(CW)) u_col (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_all),
      .inc   (inc_col[c]),
      .dec   (dec_col[c]),
      .cnt   (cnt[c]),
      .full  (full[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) state_n = DECODE;
`ifdef DROP_UNDO_EN
        else if (!clear && undo && hist_vld) state_n = UNDO;
`endif
      end
      DECODE:  state_n = (!sel_ok || full[sel_idx]) ? REJECT : COMMIT;
      default: state_n = IDLE;
    endcase
  end

  assign ready      = (state == IDLE);
  assign done       = (state == COMMIT);
  // REJECT is only reachable via a bad select or a full column, so sel_ok splits them.
  assign err_sel    = (state == REJECT) && !sel_ok;
  assign err_full   = (state == REJECT) && sel_ok;
  assign board_full = &full;

  always_comb begin
    cell_index = '1;
    if (state == COMMIT)
      cell_index = IDX_W'(cnt[sel_idx]) * IDX_W'(COLS) + IDX_W'(sel_idx);
`ifdef DROP_UNDO_EN
    else if (state == UNDO)
      cell_index = (IDX_W'(cnt[hist_col]) - IDX_W'(1)) * IDX_W'(COLS) + IDX_W'(hist_col);
`endif
  end
endmodule

// File: tb/tb_drop_controller.sv
// Bench for drop_controller (COLS=4, ROWS=4): latency-level board model checked
// every cycle, plus directed drops with hand-computed cell indices.

module tb_drop_controller;
  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset, clear, req;
  logic [COLS-1:0]  sel_col;
  logic             ready, done, err_full, err_sel, board_full;
  logic [IDX_W-1:0] cell_index;
`ifdef DROP_UNDO_EN
  logic             undo, undo_done;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  drop_controller #(.COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .req        (req),
    .sel_col    (sel_col),
`ifdef DROP_UNDO_EN
    .undo       (undo),
    .undo_done  (undo_done),
`endif
    .ready      (ready),
    .done       (done),
    .cell_index (cell_index),
    .err_full   (err_full),
    .err_sel    (err_sel),
    .board_full (board_full)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Board model: column fills, plus the pending outcome of an accepted drop.
  // age 0 = idle, 1 = being looked at, 2 = outcome visible this cycle.
  int m_cnt[COLS];
  int age, kind, m_col, m_idx, h_col, req_col;
  bit h_vld;

  function automatic int col_of(input logic [COLS-1:0] s);
    int n = 0, c = -1;
    for (int i = 0; i < COLS; i++) if (s[i] == 1'b0) begin n++; c = i; end
    return (n == 1) ? c : -1;
  endfunction

  always_comb req_col = col_of(sel_col);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) m_cnt[i] <= 0;
      age <= 0; h_vld <= 1'b0;
    end else if (age == 0) begin
      if (clear) begin
        for (int i = 0; i < COLS; i++) m_cnt[i] <= 0;
        h_vld <= 1'b0;
      end else if (req) begin
        age <= 1;
        if (req_col < 0) kind <= 2;
        else if (m_cnt[req_col] == ROWS) kind <= 1;
        else begin
          kind <= 0; m_col <= req_col; m_idx <= m_cnt[req_col] * COLS + req_col;
        end
      end
`ifdef DROP_UNDO_EN
      else if (undo && h_vld) begin
        age <= 2; kind <= 3; m_idx <= (m_cnt[h_col] - 1) * COLS + h_col;
      end
`endif
    end else if (age == 1) begin
      age <= 2;
    end else begin
      age <= 0;
      if (kind == 0) begin
        m_cnt[m_col] <= m_cnt[m_col] + 1; h_vld <= 1'b1; h_col <= m_col;
      end else if (kind == 3) begin
        m_cnt[h_col] <= m_cnt[h_col] - 1; h_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    automatic bit res = (age == 2);
    automatic bit full_all = 1'b1;
    for (int i = 0; i < COLS; i++) if (m_cnt[i] != ROWS) full_all = 1'b0;
    if (reset) begin
      check("rst_done", done, 0);
      check("rst_err", {err_full, err_sel}, 0);
      check("rst_idx", cell_index, 31);
      check("rst_bfull", board_full, 0);
    end else begin
      check("ready", ready, age == 0);
      check("done", done, res && kind == 0);
      check("err_full", err_full, res && kind == 1);
      check("err_sel", err_sel, res && kind == 2);
      check("cell_index", cell_index, (res && (kind == 0 || kind == 3)) ? m_idx : 31);
      check("board_full", board_full, full_all);
`ifdef DROP_UNDO_EN
      check("undo_done", undo_done, res && kind == 3);
`endif
    end
  end

  // One request pulse; outcome literally checked two cycles after acceptance.
  // noise keeps req/clear/alternate select asserted while the block is busy.
  task automatic drop(input logic [COLS-1:0] s, input int idx, input bit ef,
                      input bit es, input bit noise = 1'b0);
    @(posedge clk); #1 req = 1'b1; sel_col = s;
    @(posedge clk); #1
    if (noise) begin req = 1'b1; sel_col = 4'b1110; clear = 1'b1; end
    else begin req = 1'b0; sel_col = '1; end
    @(posedge clk); @(negedge clk);
    check("lit_done", done, !ef && !es);
    check("lit_err_full", err_full, ef);
    check("lit_err_sel", err_sel, es);
    check("lit_idx", cell_index, idx);
    @(posedge clk); #1 req = 1'b0; sel_col = '1; clear = 1'b0;
  endtask

`ifdef DROP_UNDO_EN
  task automatic do_undo(input bit exp_ud, input int idx);
    @(posedge clk); #1 undo = 1'b1;
    @(posedge clk); #1 undo = 1'b0;
    @(negedge clk);
    check("lit_undo_done", undo_done, exp_ud);
    check("lit_undo_idx", cell_index, idx);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    reset = 1'b1; clear = 1'b0; req = 1'b0; sel_col = '1;
`ifdef DROP_UNDO_EN
    undo = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("lit_reset_ready", ready, 1);
    check("lit_reset_idx", cell_index, 31);

    // Reset while a column-2 drop is in DECODE aborts it.
    @(posedge clk); #1 req = 1'b1; sel_col = 4'b1011;
    @(posedge clk); #1 req = 1'b0; sel_col = '1;
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("lit_abort_done", done, 0);
    check("lit_abort_ready", ready, 1);
    drop(4'b1011, 2, 0, 0);

    drop(4'b1101, 1, 0, 0);
    drop(4'b1101, 5, 0, 0);
    drop(4'b1101, 9, 0, 0, 1'b1);
    drop(4'b1101, 13, 0, 0);
    drop(4'b1101, 31, 1, 0);
    drop(4'b1100, 31, 0, 1);
    drop(4'b1111, 31, 0, 1);

    drop(4'b1110, 0, 0, 0);
    drop(4'b1110, 4, 0, 0, 1'b1);
    drop(4'b1110, 8, 0, 0);
    drop(4'b1110, 12, 0, 0);
    drop(4'b1011, 6, 0, 0);
    drop(4'b1011, 10, 0, 0);
    drop(4'b1011, 14, 0, 0);
    drop(4'b0111, 3, 0, 0);
    drop(4'b0111, 7, 0, 0);
    drop(4'b0111, 11, 0, 0);
    drop(4'b0111, 15, 0, 0);
    @(negedge clk);
    check("lit_board_full", board_full, 1);

    // Clear together with a request: clear wins, request is dropped.
    @(posedge clk); #1 clear = 1'b1; req = 1'b1; sel_col = 4'b1110;
    @(posedge clk); #1 clear = 1'b0; req = 1'b0; sel_col = '1;
    @(negedge clk);
    check("lit_clear_bfull", board_full, 0);
    check("lit_clear_ready", ready, 1);
    drop(4'b1110, 0, 0, 0);

`ifdef DROP_UNDO_EN
    drop(4'b0111, 3, 0, 0);
    do_undo(1'b1, 3);
    do_undo(1'b0, 31);
    drop(4'b0111, 3, 0, 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
